conway_grid: RTL

- Parametrised Game-of-Life engine holding a WIDTH x HEIGHT cell grid in registers.
- Host loads and reads the grid one row at a time; step_req advances one generation.
- Next generation computed one row per cycle into a shadow buffer, then committed atomically.
- Generalises the single-cell evaluator: configurable birth/survive rule masks, toroidal or dead-boundary edges, generation counter, stable detection.

---
 rtl/conway_grid.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/conway_grid.sv
// Register-resident Game-of-Life grid: the host loads and reads rows, and each step
// evaluates one row per cycle into a shadow buffer that is committed in a single edge.
module conway_grid #(
    parameter int         WIDTH        = 32,
    parameter int         HEIGHT       = 16,
    parameter int         ROW_AW       = $clog2(HEIGHT),
    parameter logic [8:0] BIRTH_MASK   = 9'h008,
    parameter logic [8:0] SURVIVE_MASK = 9'h00C,
    parameter int         WRAP         = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ROW_AW-1:0] wr_row,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ROW_AW-1:0] rd_row,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              clear,
    input  logic              step_req,
    output logic              busy,
    output logic              done,
    output logic              stable,
    output logic [15:0]       generation
);

    typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT, FINISH} state_t;

    // Masks widened so a 4-bit neighbour count indexes them without range issues.
    localparam logic [15:0]       BIRTH_LUT   = {7'd0, BIRTH_MASK};
    localparam logic [15:0]       SURVIVE_LUT = {7'd0, SURVIVE_MASK};
    localparam logic [ROW_AW-1:0] LAST_ROW    = ROW_AW'(HEIGHT - 1);
    localparam logic [ROW_AW:0]   HEIGHT_EXT  = (ROW_AW + 1)'(HEIGHT);

    state_t            state;
    logic [ROW_AW-1:0] row_idx;
    logic [WIDTH-1:0]  grid   [HEIGHT];
    logic [WIDTH-1:0]  shadow [HEIGHT];

    logic [WIDTH-1:0]  row_up, row_mid, row_dn, row_next;
    logic              grids_equal;
    logic              wr_in_range, rd_in_range;

    function automatic logic [WIDTH+1:0] extend_row(input logic [WIDTH-1:0] row);
        logic edge_lo, edge_hi;
        edge_lo = (WRAP != 0) ? row[WIDTH-1] : 1'b0;
        edge_hi = (WRAP != 0) ? row[0] : 1'b0;
        return {edge_hi, row, edge_lo};
    endfunction

    function automatic logic [WIDTH-1:0] next_row(input logic [WIDTH-1:0] up,
                                                   input logic [WIDTH-1:0] mid,
                                                   input logic [WIDTH-1:0] dn);
        logic [WIDTH+1:0] up_e, mid_e, dn_e;
        logic [3:0]       n;
        logic [WIDTH-1:0] nxt;
        up_e  = extend_row(up);
        mid_e = extend_row(mid);
        dn_e  = extend_row(dn);
        nxt   = '0;
        for (int c = 0; c < WIDTH; c++) begin
            n = 4'(up_e[c]) + 4'(up_e[c+1]) + 4'(up_e[c+2])
              + 4'(mid_e[c]) + 4'(mid_e[c+2])
              + 4'(dn_e[c]) + 4'(dn_e[c+1]) + 4'(dn_e[c+2]);
            nxt[c] = mid[c] ? SURVIVE_LUT[n] : BIRTH_LUT[n];
        end
        return nxt;
    endfunction

    assign wr_in_range = ({1'b0, wr_row} < HEIGHT_EXT);
    assign rd_in_range = ({1'b0, rd_row} < HEIGHT_EXT);

    // Neighbour rows always come from the live grid, so shadow rows never feed back.
    always_comb begin
        row_mid = grid[row_idx];
        row_up  = '0;
        row_dn  = '0;
        if (row_idx == '0) begin
            if (WRAP != 0) row_up = grid[HEIGHT-1];
        end else begin
            row_up = grid[row_idx - ROW_AW'(1)];
        end
        if (row_idx == LAST_ROW) begin
            if (WRAP != 0) row_dn = grid[0];
        end else begin
            row_dn = grid[row_idx + ROW_AW'(1)];
        end
        row_next = next_row(row_up, row_mid, row_dn);
    end

    always_comb begin
        grids_equal = 1'b1;
        for (int i = 0; i < HEIGHT; i++)
            if (shadow[i] != grid[i]) grids_equal = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stable     <= 1'b0;
            generation <= '0;
            rd_data    <= '0;
            for (int i = 0; i < HEIGHT; i++) begin
                grid[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            rd_data <= rd_in_range ? grid[rd_row] : '0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        for (int i = 0; i < HEIGHT; i++) grid[i] <= '0;
                        generation <= '0;
                        stable     <= 1'b0;
                    end else begin
                        if (wr_en && wr_in_range) grid[wr_row] <= wr_data;
                        if (step_req) begin
                            state   <= COMPUTE;
                            busy    <= 1'b1;
                            row_idx <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    shadow[row_idx] <= row_next;
                    if (row_idx == LAST_ROW) begin
                        row_idx <= '0;
                        state   <= COMMIT;
                    end else begin
                        row_idx <= row_idx + ROW_AW'(1);
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < HEIGHT; i++) grid[i] <= shadow[i];
                    stable     <= grids_equal;
                    generation <= generation + 16'd1;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= FINISH;
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
